// File: rtl/stack_exec.sv
// Stack-machine execute unit: pops one operator and two operands, evaluates
// A op B (add/sub/mul in one cycle, div as a 17-cycle restoring divider),
// pushes the result back and pulses complete. Underflow and divide-by-zero
// set a sticky error flag.
//
// state  | meaning
// IDLE   | waiting for start
// POP_OP | operator on op_data is latched, op_pop strobed
// POP_B  | top operand latched as B (or underflow abort)
// POP_A  | next operand latched as A (or underflow abort)
// EXEC   | compute; divide iterates here for 16 steps plus a sign-fix cycle
// PUSH   | result presented with opnd_push_EX
// DONE   | complete pulse, back to IDLE
module stack_exec (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  op_data,
    input  logic [15:0] opnd_data,
    input  logic        opnd_empty,
    output logic        op_pop,
    output logic        opnd_pop,
    output logic        opnd_push_EX,
    output logic [15:0] result,
    output logic        complete,
    output logic        busy,
    output logic        err
);

    typedef enum logic [2:0] {IDLE, POP_OP, POP_B, POP_A, EXEC, PUSH, DONE} state_t;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_DIV = 2'b11;

    state_t      state_q;
    logic [1:0]  op_q;
    logic [15:0] a_q, b_q;
    logic [15:0] rem_q, quo_q;
    logic [4:0]  div_cnt_q;
    logic [15:0] result_q;
    logic        op_pop_q, push_q, complete_q, busy_q, err_q;

    logic [15:0] a_mag_d, b_mag_d;
    logic [16:0] rem_shift_d;
    logic [15:0] rem_sub_d, rem_d, quo_d;
    logic [15:0] alu_d;

    // One restoring-division step on magnitudes, plus the single-cycle ALU
    // result (division result is sign-corrected from the finished quotient).
    always_comb begin
        a_mag_d     = opnd_data[15] ? (16'd0 - opnd_data) : opnd_data;
        b_mag_d     = b_q[15] ? (16'd0 - b_q) : b_q;
        rem_shift_d = {rem_q, quo_q[15]};
        rem_sub_d   = 16'(rem_shift_d - {1'b0, b_mag_d});
        if (rem_shift_d >= {1'b0, b_mag_d}) begin
            rem_d = rem_sub_d;
            quo_d = {quo_q[14:0], 1'b1};
        end else begin
            rem_d = rem_shift_d[15:0];
            quo_d = {quo_q[14:0], 1'b0};
        end
        case (op_q)
            OP_ADD:  alu_d = a_q + b_q;
            OP_SUB:  alu_d = a_q - b_q;
            OP_MUL:  alu_d = 16'(a_q * b_q);
            default: begin
                if (b_q == 16'd0)
                    alu_d = 16'd0;
                else if (a_q[15] ^ b_q[15])
                    alu_d = 16'd0 - quo_q;
                else
                    alu_d = quo_q;
            end
        endcase
    end

    // Sequencer with registered strobes; strobes default low every cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            op_q       <= OP_ADD;
            a_q        <= 16'd0;
            b_q        <= 16'd0;
            rem_q      <= 16'd0;
            quo_q      <= 16'd0;
            div_cnt_q  <= 5'd0;
            result_q   <= 16'd0;
            op_pop_q   <= 1'b0;
            push_q     <= 1'b0;
            complete_q <= 1'b0;
            busy_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            op_pop_q   <= 1'b0;
            push_q     <= 1'b0;
            complete_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q  <= POP_OP;
                        op_pop_q <= 1'b1;
                        busy_q   <= 1'b1;
                    end
                end
                POP_OP: begin
                    op_q    <= op_data;
                    state_q <= POP_B;
                end
                POP_B: begin
                    if (opnd_empty) begin
                        err_q      <= 1'b1;
                        complete_q <= 1'b1;
                        state_q    <= DONE;
                    end else begin
                        b_q     <= opnd_data;
                        state_q <= POP_A;
                    end
                end
                POP_A: begin
                    if (opnd_empty) begin
                        err_q      <= 1'b1;
                        complete_q <= 1'b1;
                        state_q    <= DONE;
                    end else begin
                        a_q       <= opnd_data;
                        quo_q     <= a_mag_d;
                        rem_q     <= 16'd0;
                        div_cnt_q <= 5'd16;
                        state_q   <= EXEC;
                    end
                end
                EXEC: begin
                    if (op_q == OP_DIV && div_cnt_q != 5'd0) begin
                        rem_q     <= rem_d;
                        quo_q     <= quo_d;
                        div_cnt_q <= div_cnt_q - 5'd1;
                    end else begin
                        result_q <= alu_d;
                        push_q   <= 1'b1;
                        state_q  <= PUSH;
                        if (op_q == OP_DIV && b_q == 16'd0)
                            err_q <= 1'b1;
                    end
                end
                PUSH: begin
                    complete_q <= 1'b1;
                    state_q    <= DONE;
                end
                DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // The operand pop must react to opnd_empty in the same cycle, so it is
    // decoded from the state register rather than registered ahead of time.
    assign opnd_pop     = ((state_q == POP_B) || (state_q == POP_A)) && !opnd_empty;
    assign op_pop       = op_pop_q;
    assign opnd_push_EX = push_q;
    assign result       = result_q;
    assign complete     = complete_q;
    assign busy         = busy_q;
    assign err          = err_q;

endmodule

// File: tb/tb_stack_exec.sv
module tb_stack_exec;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  op_data = 2'b00;
    logic [15:0] opnd_data = 16'hDEAD;
    logic        opnd_empty = 1'b1;
    logic        op_pop, opnd_pop, opnd_push_EX, complete, busy, err;
    logic [15:0] result;

    int errors = 0;
    int checks = 0;

    logic [15:0] stk[$];
    logic        pend_pop, pend_push;
    logic [15:0] pend_val;
    logic        err_exp;
    logic [15:0] last_res;

    typedef struct {
        logic [1:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] res;
        logic        dz;
        bit          repulse;
    } vec_t;
    vec_t vecs[10];

    stack_exec dut (
        .clk(clk), .reset(reset), .start(start), .op_data(op_data),
        .opnd_data(opnd_data), .opnd_empty(opnd_empty), .op_pop(op_pop),
        .opnd_pop(opnd_pop), .opnd_push_EX(opnd_push_EX), .result(result),
        .complete(complete), .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, act, act, exp, exp);
        end
    endtask

    // Reference: signed integer arithmetic, C-style truncating division.
    function automatic void ref_op(input logic [1:0] op, input logic [15:0] a,
                                   input logic [15:0] b, output logic [15:0] res,
                                   output logic dz);
        int sa, sb, r;
        sa = int'($signed(a));
        sb = int'($signed(b));
        dz = 1'b0;
        case (op)
            2'd0: r = sa + sb;
            2'd1: r = sa - sb;
            2'd2: r = sa * sb;
            default: begin
                if (sb == 0) begin
                    r  = 0;
                    dz = 1'b1;
                end else begin
                    r = sa / sb;
                end
            end
        endcase
        res = r[15:0];
    endfunction

    task automatic drive_stack();
        opnd_empty = (stk.size() == 0);
        opnd_data  = (stk.size() == 0) ? 16'hDEAD : stk[$];
    endtask

    // One clock: apply the stack effects of last cycle's strobes after the
    // edge, then sample the new cycle's outputs on the falling edge.
    task automatic step();
        @(posedge clk);
        #1;
        if (pend_pop && stk.size() > 0) void'(stk.pop_back());
        if (pend_push) stk.push_back(pend_val);
        drive_stack();
        @(negedge clk);
        pend_pop  = opnd_pop;
        pend_push = opnd_push_EX;
        pend_val  = result;
    endtask

    task automatic do_reset(input string nm);
        reset = 1'b1;
        start = 1'b1;
        step();
        chk({nm, "_busy"}, int'(busy), 0);
        chk({nm, "_strobes"}, int'({op_pop, opnd_pop, opnd_push_EX, complete}), 0);
        chk({nm, "_err"}, int'(err), 0);
        chk({nm, "_result"}, int'(result), 0);
        reset = 1'b0;
        start = 1'b0;
        err_exp  = 1'b0;
        last_res = 16'd0;
    endtask

    task automatic run_op(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b,
                          input int nopnd, input logic [15:0] exp_res, input logic exp_dz,
                          input bit repulse, input string nm);
        int lat, exp_pops, exp_push;
        int op_cnt, op_cyc, pop_cnt, push_cnt, push_cyc, comp_cyc, busy_cnt, overlap;
        logic [15:0] push_val;
        stk.delete();
        if (nopnd >= 2) stk.push_back(a);
        if (nopnd >= 1) stk.push_back(b);
        pend_pop  = 1'b0;
        pend_push = 1'b0;
        drive_stack();
        op_data = op;
        if (nopnd >= 2) begin
            lat      = (op == 2'd3) ? 21 : 5;
            exp_pops = 2;
            exp_push = 1;
            err_exp  = err_exp | exp_dz;
            last_res = exp_res;
        end else begin
            lat      = nopnd + 2;
            exp_pops = nopnd;
            exp_push = 0;
            err_exp  = 1'b1;
        end
        op_cnt = 0; op_cyc = -1; pop_cnt = 0; push_cnt = 0; push_cyc = -1;
        comp_cyc = -1; busy_cnt = 0; overlap = 0; push_val = 16'd0;
        start = 1'b1;
        for (int c = 0; c < 40 && comp_cyc < 0; c++) begin
            step();
            if (op_pop) begin
                op_cnt++;
                if (op_cyc < 0) op_cyc = c;
            end
            if (opnd_pop) pop_cnt++;
            if (opnd_push_EX) begin
                push_cnt++;
                push_cyc = c;
                push_val = result;
            end
            if (busy) busy_cnt++;
            if (int'(op_pop) + int'(opnd_pop) + int'(opnd_push_EX) > 1) overlap++;
            if (complete) comp_cyc = c;
            start = (repulse && c >= 1 && c <= 3) ? 1'b1 : 1'b0;
        end
        start = 1'b0;
        chk({nm, "_op_pops"}, op_cnt, 1);
        chk({nm, "_op_pop_cyc"}, op_cyc, 0);
        chk({nm, "_opnd_pops"}, pop_cnt, exp_pops);
        chk({nm, "_pushes"}, push_cnt, exp_push);
        chk({nm, "_complete_cyc"}, comp_cyc, lat);
        chk({nm, "_busy_cycles"}, busy_cnt, lat + 1);
        chk({nm, "_strobe_overlap"}, overlap, 0);
        if (exp_push == 1) begin
            chk({nm, "_push_cyc"}, push_cyc, lat - 1);
            chk({nm, "_push_val"}, int'(push_val), int'(exp_res));
        end
        step();
        chk({nm, "_idle_after"}, int'({busy, complete}), 0);
        chk({nm, "_result_held"}, int'(result), int'(last_res));
        chk({nm, "_err"}, int'(err), int'(err_exp));
    endtask

    function automatic logic [15:0] pick_val();
        case ($urandom_range(0, 7))
            0: return 16'h8000;
            1: return 16'h7FFF;
            2: return 16'hFFFF;
            3: return 16'h0001;
            default: return 16'($urandom);
        endcase
    endfunction

    initial begin
        logic [15:0] ra, rb, rres;
        logic        rdz;
        int          nop, noact;

        vecs[0] = '{2'd1, 16'd7,      16'd5,      16'h0002, 1'b0, 1'b0};
        vecs[1] = '{2'd3, 16'hFFF9,   16'd2,      16'hFFFD, 1'b0, 1'b0};
        vecs[2] = '{2'd2, 16'd300,    16'd300,    16'h5F90, 1'b0, 1'b0};
        vecs[3] = '{2'd0, 16'h7FFF,   16'd1,      16'h8000, 1'b0, 1'b0};
        vecs[4] = '{2'd3, 16'h8000,   16'hFFFF,   16'h8000, 1'b0, 1'b0};
        vecs[5] = '{2'd3, 16'd7,      16'hFFFE,   16'hFFFD, 1'b0, 1'b0};
        vecs[6] = '{2'd1, 16'h8000,   16'd1,      16'h7FFF, 1'b0, 1'b0};
        vecs[7] = '{2'd2, 16'hFFFE,   16'd3,      16'hFFFA, 1'b0, 1'b0};
        vecs[8] = '{2'd3, 16'd100,    16'd7,      16'h000E, 1'b0, 1'b0};
        vecs[9] = '{2'd3, 16'd9,      16'd0,      16'h0000, 1'b1, 1'b1};

        pend_pop = 1'b0; pend_push = 1'b0; pend_val = 16'd0;
        err_exp = 1'b0; last_res = 16'd0;
        drive_stack();

        do_reset("reset0");

        for (int i = 0; i < 10; i++)
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, 2, vecs[i].res, vecs[i].dz,
                   vecs[i].repulse, $sformatf("vec%0d", i));

        // Underflow: one operand, then a valid add must still run with err held.
        do_reset("reset1");
        run_op(2'd0, 16'd0, 16'd4, 1, 16'd0, 1'b0, 1'b0, "under1");
        run_op(2'd0, 16'd3, 16'd4, 2, 16'd7, 1'b0, 1'b0, "after_under");
        run_op(2'd1, 16'd0, 16'd0, 0, 16'd0, 1'b0, 1'b0, "under0");

        // Reset in the middle of a divide aborts cleanly.
        stk.delete();
        stk.push_back(16'd9);
        stk.push_back(16'd2);
        pend_pop = 1'b0; pend_push = 1'b0;
        drive_stack();
        op_data = 2'd3;
        start = 1'b1;
        for (int c = 0; c < 10; c++) begin
            step();
            start = 1'b0;
        end
        chk("middiv_busy_before", int'(busy), 1);
        reset = 1'b1;
        step();
        chk("middiv_busy", int'(busy), 0);
        chk("middiv_strobes", int'({op_pop, opnd_pop, opnd_push_EX, complete}), 0);
        chk("middiv_err", int'(err), 0);
        reset = 1'b0;
        err_exp = 1'b0;
        last_res = 16'd0;
        noact = 0;
        for (int c = 0; c < 3; c++) begin
            step();
            if (complete || busy || opnd_push_EX) noact++;
        end
        chk("middiv_quiet", noact, 0);
        run_op(2'd1, 16'd20, 16'd6, 2, 16'd14, 1'b0, 1'b0, "middiv_fresh");

        // Randomized operations against the arithmetic reference.
        for (int i = 0; i < 60; i++) begin
            ra = pick_val();
            rb = ($urandom_range(0, 9) == 0) ? 16'd0 : pick_val();
            nop = ($urandom_range(0, 11) == 0) ? int'($urandom_range(0, 1)) : 2;
            ref_op(2'($urandom_range(0, 3)), ra, rb, rres, rdz);
            op_data = 2'd0;
            begin
                logic [1:0] rop;
                rop = 2'($urandom_range(0, 3));
                ref_op(rop, ra, rb, rres, rdz);
                run_op(rop, ra, rb, nop, rres, rdz, 1'b0, $sformatf("rand%0d", i));
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/stack_exec.md
STACK_EXEC -- requirements
Module: stack_exec

Interface
REQ-001 SHALL have port: clk  input  1  single system clock, all state updates on rising edge.
REQ-002 SHALL have port: reset  input  1  synchronous, active-high reset, sampled on rising edge of clk.
REQ-003 SHALL have port: start  input  1  request from stack controller to evaluate one operator.
REQ-004 SHALL have port: op_data  input  2  top of operator stack: 00 add, 01 sub, 10 mul, 11 div.
REQ-005 SHALL have port: opnd_data  input  16  top of operand stack, signed two's complement, valid combinationally.
REQ-006 SHALL have port: opnd_empty  input  1  operand stack holds no entries.
REQ-007 SHALL have port: op_pop  output  1  one-cycle pop strobe to operator stack.
REQ-008 SHALL have port: opnd_pop  output  1  one-cycle pop strobe to operand stack.
REQ-009 SHALL have port: opnd_push_EX  output  1  one-cycle push strobe of result to operand stack.
REQ-010 SHALL have port: result  output  16  computed value, valid while opnd_push_EX is high and held until next operation.
REQ-011 SHALL have port: complete  output  1  one-cycle done pulse to stack controller.
REQ-012 SHALL have port: busy  output  1  high in every state except IDLE.
REQ-013 SHALL have port: err  output  1  sticky error flag (underflow or divide by zero).

Function
REQ-014 SHALL implement states IDLE, POP_OP, POP_B, POP_A, EXEC, PUSH, DONE.
REQ-015 IDLE: start=1 -> POP_OP; start is ignored in every other state.
REQ-016 POP_OP: latch op_data, assert op_pop; -> POP_B.
REQ-017 POP_B: if opnd_empty -> DONE with err set and no push; else latch opnd_data as B, assert opnd_pop; -> POP_A.
REQ-018 POP_A: if opnd_empty -> DONE with err set and no push; else latch opnd_data as A, assert opnd_pop; -> EXEC.
REQ-019 EXEC: compute A op B; add, sub and mul occupy 1 cycle; div occupies 17 cycles (16 restoring iterations on magnitudes plus 1 sign-fix cycle); -> PUSH.
REQ-020 Add/sub SHALL wrap modulo 2^16; mul SHALL keep the low 16 bits of the signed product; no overflow flag.
REQ-021 Div SHALL truncate toward zero; -32768 / -1 SHALL yield -32768.
REQ-022 Div with B=0 SHALL produce result 0x0000, set err, and still push.
REQ-023 PUSH: assert opnd_push_EX for exactly 1 cycle with result stable; -> DONE.
REQ-024 DONE: assert complete for exactly 1 cycle; -> IDLE.
REQ-025 Latency, counted from the clk edge that samples start=1: complete high during the cycle after the 5th following edge for add/sub/mul, and 16 cycles later for div.
REQ-026 The sequence SHALL assert at most one of op_pop, opnd_pop or opnd_push_EX in any cycle.
REQ-027 err SHALL stay high once set until reset, and SHALL NOT block later operations.
REQ-028 An underflow abort SHALL still produce the complete pulse, so the controller never hangs.

Reset
REQ-029 reset=1 SHALL force IDLE and drive op_pop, opnd_pop, opnd_push_EX, complete, busy and err to 0, result to 0x0000, and clear the divider counter.
REQ-030 Reset asserted mid-operation, including during div iterations, SHALL abort with no push and no complete pulse; reset takes priority over start.

Verification
REQ-031 Stack top B=5, next A=7, op=sub, start pulse -> op_pop, then two opnd_pop, then opnd_push_EX with result=0x0002, then complete 1 cycle later; err=0.
REQ-032 A=-7 (0xFFF9), B=2, op=div -> busy spans 17 EXEC cycles, result=0xFFFD (-3), complete at latency 5+16.
REQ-033 A=300, B=300, op=mul -> result=0x5F90 (90000 mod 2^16); A=0x7FFF, B=1, op=add -> result=0x8000; err=0 in both cases.
REQ-034 One operand only (opnd_empty rises after first pop) -> a single opnd_pop, no opnd_push_EX, complete pulses, err=1 and stays 1 through a following valid add.
REQ-035 A=9, B=0, op=div -> result=0x0000 pushed, err=1; start re-pulsed while busy -> no effect.
REQ-036 reset asserted in EXEC of a div -> next cycle busy=0, all strobes 0, err=0, no complete; a fresh start then runs normally.
